// File: rtl/midi_msg_decoder.sv
// MIDI channel-message byte decoder: tracks status/running status, frames data bytes
// and emits a one-cycle trigger toward the note stack; SysEx payloads and realtime bytes are skipped.
module midi_msg_decoder #(
  parameter bit         OMNI_DEFAULT = 1'b1,
  parameter logic [3:0] CH_DEFAULT   = 4'd0
) (
  input  logic       reg_clk,
  input  logic       reset_reg,
  input  logic [7:0] midi_byte,
  input  logic       midi_byte_valid,
  input  logic       omni,
  input  logic [3:0] listen_ch,
  output logic [7:0] seq_databyte,
  output logic       is_data_byte,
  output logic       is_velocity,
  output logic       is_st_note_on,
  output logic       is_st_note_off,
  output logic       is_st_ctrl,
  output logic [3:0] msg_ch,
  output logic       trig__note_stack,
  output logic       realtime_strobe,
  output logic [7:0] realtime_byte,
  output logic       sysex_active
);

  // OMNI_DEFAULT/CH_DEFAULT document the tie-off values of omni/listen_ch; the ports are used directly.
  if (OMNI_DEFAULT && (CH_DEFAULT != 4'd0)) begin : g_cfg_tie_off_note
  end

  typedef enum logic [1:0] {IDLE, WAIT_D1, WAIT_D2, SYSEX} state_t;

  state_t     state_q, state_d;
  logic       two_byte_q, two_byte_d;
  logic [7:0] data_q, data_d;
  logic       d1_q, d1_d;
  logic       vel_q, vel_d;
  logic       on_q, on_d;
  logic       off_q, off_d;
  logic       ctrl_q, ctrl_d;
  logic [3:0] ch_q, ch_d;
  logic       trig_q, trig_d;
  logic       rt_stb_q, rt_stb_d;
  logic [7:0] rt_byte_q, rt_byte_d;
  logic       sysex_q, sysex_d;
  logic       accept;

  assign accept = omni | (ch_q == listen_ch);

  always_ff @(posedge reg_clk or posedge reset_reg) begin
    if (reset_reg) begin
      state_q    <= IDLE;
      two_byte_q <= 1'b0;
      data_q     <= 8'h00;
      d1_q       <= 1'b0;
      vel_q      <= 1'b0;
      on_q       <= 1'b0;
      off_q      <= 1'b0;
      ctrl_q     <= 1'b0;
      ch_q       <= 4'h0;
      trig_q     <= 1'b0;
      rt_stb_q   <= 1'b0;
      rt_byte_q  <= 8'h00;
      sysex_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      two_byte_q <= two_byte_d;
      data_q     <= data_d;
      d1_q       <= d1_d;
      vel_q      <= vel_d;
      on_q       <= on_d;
      off_q      <= off_d;
      ctrl_q     <= ctrl_d;
      ch_q       <= ch_d;
      trig_q     <= trig_d;
      rt_stb_q   <= rt_stb_d;
      rt_byte_q  <= rt_byte_d;
      sysex_q    <= sysex_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    two_byte_d = two_byte_q;
    data_d     = data_q;
    d1_d       = d1_q;
    vel_d      = vel_q;
    on_d       = on_q;
    off_d      = off_q;
    ctrl_d     = ctrl_q;
    ch_d       = ch_q;
    trig_d     = 1'b0;
    rt_stb_d   = 1'b0;
    rt_byte_d  = rt_byte_q;
    sysex_d    = sysex_q;

    if (midi_byte_valid) begin
      if (midi_byte >= 8'hF8) begin
        // Realtime bytes never touch framing, even inside a message or SysEx.
        rt_byte_d = midi_byte;
        rt_stb_d  = 1'b1;
      end else if (midi_byte[7]) begin
        if (midi_byte < 8'hF0) begin
          state_d    = WAIT_D1;
          ch_d       = midi_byte[3:0];
          on_d       = (midi_byte[7:4] == 4'h9);
          off_d      = (midi_byte[7:4] == 4'h8);
          ctrl_d     = (midi_byte[7:4] == 4'hB);
          two_byte_d = (midi_byte[7:4] != 4'hC) && (midi_byte[7:4] != 4'hD);
          d1_d       = 1'b0;
          vel_d      = 1'b0;
          sysex_d    = 1'b0;
        end else if (midi_byte == 8'hF0) begin
          state_d    = SYSEX;
          sysex_d    = 1'b1;
          two_byte_d = 1'b0;
          on_d       = 1'b0;
          off_d      = 1'b0;
          ctrl_d     = 1'b0;
        end else begin
          // F1..F7: end of SysEx or system common; running status is dropped either way.
          state_d    = IDLE;
          two_byte_d = 1'b0;
          sysex_d    = 1'b0;
        end
      end else begin
        case (state_q)
          WAIT_D1: begin
            data_d  = midi_byte;
            d1_d    = 1'b1;
            vel_d   = 1'b0;
            trig_d  = accept;
            state_d = two_byte_q ? WAIT_D2 : WAIT_D1;
          end
          WAIT_D2: begin
            data_d  = midi_byte;
            d1_d    = 1'b0;
            vel_d   = 1'b1;
            trig_d  = accept;
            state_d = WAIT_D1;
          end
          default: ;
        endcase
      end
    end
  end

  assign seq_databyte     = data_q;
  assign is_data_byte     = d1_q;
  assign is_velocity      = vel_q;
  assign is_st_note_on    = on_q;
  assign is_st_note_off   = off_q;
  assign is_st_ctrl       = ctrl_q;
  assign msg_ch           = ch_q;
  assign trig__note_stack = trig_q;
  assign realtime_strobe  = rt_stb_q;
  assign realtime_byte    = rt_byte_q;
  assign sysex_active     = sysex_q;

endmodule

// File: tb/tb_midi_msg_decoder.sv
// Directed bench for midi_msg_decoder: hand-computed expectations checked with immediate assertions.
module tb_midi_msg_decoder;
  logic       reg_clk = 1'b0;
  logic       reset_reg = 1'b1;
  logic [7:0] midi_byte = 8'h00;
  logic       midi_byte_valid = 1'b0;
  logic       omni = 1'b1;
  logic [3:0] listen_ch = 4'd0;
  logic [7:0] seq_databyte;
  logic       is_data_byte, is_velocity, is_st_note_on, is_st_note_off, is_st_ctrl;
  logic [3:0] msg_ch;
  logic       trig__note_stack, realtime_strobe, sysex_active;
  logic [7:0] realtime_byte;

  int checks = 0;
  int errors = 0;

  midi_msg_decoder dut (
    .reg_clk(reg_clk), .reset_reg(reset_reg), .midi_byte(midi_byte),
    .midi_byte_valid(midi_byte_valid), .omni(omni), .listen_ch(listen_ch),
    .seq_databyte(seq_databyte), .is_data_byte(is_data_byte), .is_velocity(is_velocity),
    .is_st_note_on(is_st_note_on), .is_st_note_off(is_st_note_off), .is_st_ctrl(is_st_ctrl),
    .msg_ch(msg_ch), .trig__note_stack(trig__note_stack), .realtime_strobe(realtime_strobe),
    .realtime_byte(realtime_byte), .sysex_active(sysex_active)
  );

  always #5 reg_clk = ~reg_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] all_out();
    return {4'h0, seq_databyte, is_data_byte, is_velocity, is_st_note_on, is_st_note_off,
            is_st_ctrl, msg_ch, trig__note_stack, realtime_strobe, realtime_byte, sysex_active};
  endfunction

  // Byte stays valid until the next send or idle, so consecutive sends are back-to-back.
  task automatic send(input logic [7:0] b);
    @(negedge reg_clk);
    midi_byte = b;
    midi_byte_valid = 1'b1;
    @(posedge reg_clk);
    #1;
  endtask

  task automatic idle();
    @(negedge reg_clk);
    midi_byte_valid = 1'b0;
    @(posedge reg_clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge reg_clk);
    #1;
    chk("reset_all_zero", all_out(), 32'h0);
    @(negedge reg_clk);
    reset_reg = 1'b0;

    // 1: 90 3C 64
    send(8'h90);
    chk("t1_status_on", {is_st_note_on, is_st_note_off, is_st_ctrl, trig__note_stack}, 4'b1000);
    chk("t1_status_ch", msg_ch, 4'h0);
    send(8'h3C);
    chk("t1_d1", {trig__note_stack, is_data_byte, is_velocity, seq_databyte}, {3'b110, 8'h3C});
    send(8'h64);
    chk("t1_d2", {trig__note_stack, is_data_byte, is_velocity, seq_databyte}, {3'b101, 8'h64});

    // 2: running status 40 00
    send(8'h40);
    chk("t2_d1", {trig__note_stack, is_data_byte, is_velocity, seq_databyte}, {3'b110, 8'h40});
    send(8'h00);
    chk("t2_d2_vel0", {trig__note_stack, is_data_byte, is_velocity, is_st_note_on, seq_databyte}, {4'b1011, 8'h00});
    idle();
    chk("idle_pulse_drop", {trig__note_stack, is_velocity, seq_databyte}, {2'b01, 8'h00});

    // 3: 90 3C F8 64
    send(8'h90);
    send(8'h3C);
    chk("t3_d1", {trig__note_stack, seq_databyte}, {1'b1, 8'h3C});
    send(8'hF8);
    chk("t3_rt", {realtime_strobe, realtime_byte, trig__note_stack, is_data_byte, seq_databyte},
        {1'b1, 8'hF8, 2'b01, 8'h3C});
    send(8'h64);
    chk("t3_d2", {realtime_strobe, trig__note_stack, is_velocity, seq_databyte}, {3'b011, 8'h64});

    // Status then realtime on consecutive cycles
    send(8'h85);
    chk("b2b_status", {is_st_note_off, is_st_note_on, msg_ch, is_data_byte}, {2'b10, 4'h5, 1'b0});
    send(8'hFA);
    chk("b2b_rt", {realtime_strobe, realtime_byte, is_st_note_off, msg_ch}, {1'b1, 8'hFA, 1'b1, 4'h5});
    send(8'h30);
    chk("b2b_data", {trig__note_stack, is_data_byte, seq_databyte}, {2'b11, 8'h30});

    // 4: F0 7E 3C 64 F7 3C
    send(8'hF0);
    chk("t4_sysex_on", {sysex_active, is_st_note_on, is_st_note_off, is_st_ctrl, trig__note_stack}, 5'b10000);
    send(8'h7E);
    chk("t4_7e", {sysex_active, trig__note_stack, seq_databyte}, {2'b10, 8'h30});
    send(8'h3C);
    chk("t4_3c", {sysex_active, trig__note_stack}, 2'b10);
    send(8'h64);
    chk("t4_64", {sysex_active, trig__note_stack}, 2'b10);
    send(8'hF7);
    chk("t4_f7", {sysex_active, trig__note_stack}, 2'b00);
    send(8'h3C);
    chk("t4_idle_data", {sysex_active, trig__note_stack, seq_databyte}, {2'b00, 8'h30});

    // 5: omni=0, listen_ch=2
    idle();
    omni = 1'b0;
    listen_ch = 4'd2;
    send(8'h91);
    send(8'h3C);
    chk("t5_ch1_d1", {trig__note_stack, is_data_byte, seq_databyte}, {2'b01, 8'h3C});
    send(8'h64);
    chk("t5_ch1_d2", {trig__note_stack, is_velocity, seq_databyte}, {2'b01, 8'h64});
    send(8'h92);
    chk("t5_ch2_status", msg_ch, 4'h2);
    send(8'h3C);
    chk("t5_ch2_d1", {trig__note_stack, seq_databyte}, {1'b1, 8'h3C});
    send(8'h64);
    chk("t5_ch2_d2", {trig__note_stack, is_velocity, seq_databyte}, {2'b11, 8'h64});
    omni = 1'b1;

    // One-byte message keeps running status in WAIT_D1
    send(8'hC5);
    send(8'h10);
    chk("pc_d1", {trig__note_stack, is_data_byte, is_velocity, seq_databyte}, {3'b110, 8'h10});
    send(8'h20);
    chk("pc_running", {trig__note_stack, is_data_byte, is_velocity, seq_databyte}, {3'b110, 8'h20});

    // System common drops running status
    send(8'h90);
    send(8'h3C);
    send(8'hF3);
    send(8'h64);
    chk("f3_drop", {trig__note_stack, seq_databyte}, {1'b0, 8'h3C});

    // 6: 90 3C, reset, 64, then B0 7B 00
    send(8'h90);
    send(8'h3C);
    #2 reset_reg = 1'b1;
    #1;
    chk("t6_reset_zero", all_out(), 32'h0);
    @(negedge reg_clk);
    midi_byte_valid = 1'b0;
    reset_reg = 1'b0;
    send(8'h64);
    chk("t6_after_reset", all_out(), 32'h0);
    send(8'hB0);
    chk("t6_ctrl_status", {is_st_ctrl, is_st_note_on, trig__note_stack}, 3'b100);
    send(8'h7B);
    chk("t6_ctrl_d1", {trig__note_stack, is_st_ctrl, is_data_byte, seq_databyte}, {3'b111, 8'h7B});
    send(8'h00);
    chk("t6_ctrl_d2", {trig__note_stack, is_st_ctrl, is_velocity, seq_databyte}, {3'b111, 8'h00});
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
